// File: rtl/branch_resolve.sv
// EX-stage conditional branch resolution for a MIPS pipeline.
// Resolves BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ, drives flush/redirect and counts outcomes.
module branch_resolve #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic [31:0]      id_pc,
    input  logic             id_predtaken,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    output logic             br_valid,
    output logic             istaken,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [4:0] RT_BLTZ   = 5'd0;
    localparam logic [4:0] RT_BGEZ   = 5'd1;

    logic             ex_valid_q;
    logic [31:0]      ex_instr_q;
    logic [31:0]      ex_pc_q;
    logic             ex_pred_q;
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] mp_count_q, mp_count_d;

    logic [5:0]  opcode;
    logic [4:0]  rt_field;
    logic [15:0] imm;
    logic        is_branch;
    logic        cond;
    logic        rs_neg;
    logic        rs_zero;
    logic        resolve;
    logic        mispred;
    logic [31:0] seq_pc;
    logic [31:0] target;
    logic        unused_rs;

    assign opcode    = ex_instr_q[31:26];
    assign rt_field  = ex_instr_q[20:16];
    assign imm       = ex_instr_q[15:0];
    assign unused_rs = ^ex_instr_q[25:21];

    assign rs_neg  = rs_val[31];
    assign rs_zero = (rs_val == 32'd0);

    always_comb begin
        is_branch = 1'b0;
        cond      = 1'b0;
        unique case (opcode)
            OP_BEQ: begin
                is_branch = 1'b1;
                cond      = (rs_val == rt_val);
            end
            OP_BNE: begin
                is_branch = 1'b1;
                cond      = (rs_val != rt_val);
            end
            OP_BLEZ: begin
                is_branch = 1'b1;
                cond      = rs_neg | rs_zero;
            end
            OP_BGTZ: begin
                is_branch = 1'b1;
                cond      = ~rs_neg & ~rs_zero;
            end
            OP_REGIMM: begin
                if (rt_field == RT_BLTZ) begin
                    is_branch = 1'b1;
                    cond      = rs_neg;
                end else if (rt_field == RT_BGEZ) begin
                    is_branch = 1'b1;
                    cond      = ~rs_neg;
                end
            end
            default: begin
                is_branch = 1'b0;
                cond      = 1'b0;
            end
        endcase
    end

    // No delay slot: fall-through is the next sequential word.
    assign seq_pc = ex_pc_q + 32'd4;
    assign target = seq_pc + {{14{imm[15]}}, imm, 2'b00};

    assign resolve = ex_valid_q & is_branch & ~stall;
    assign mispred = resolve & (cond != ex_pred_q);

    assign br_valid    = resolve;
    assign istaken     = resolve & cond;
    assign flush       = mispred;
    assign redirect_pc = mispred ? (cond ? target : seq_pc) : 32'd0;

    always_comb begin
        br_count_d = br_count_q;
        mp_count_d = mp_count_q;
        if (resolve && (br_count_q != {CNT_W{1'b1}})) begin
            br_count_d = br_count_q + 1'b1;
        end
        if (mispred && (mp_count_q != {CNT_W{1'b1}})) begin
            mp_count_d = mp_count_q + 1'b1;
        end
    end

    // A mispredict squashes whatever ID holds, so EX takes a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_instr_q <= 32'd0;
            ex_pc_q    <= 32'd0;
            ex_pred_q  <= 1'b0;
        end else if (!stall) begin
            ex_valid_q <= id_valid & ~mispred;
            ex_instr_q <= id_instr;
            ex_pc_q    <= id_pc;
            ex_pred_q  <= id_predtaken;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_q <= '0;
            mp_count_q <= '0;
        end else begin
            br_count_q <= br_count_d;
            mp_count_q <= mp_count_d;
        end
    end

    assign br_count = br_count_q;
    assign mp_count = mp_count_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: ISA-level model plus literal checks.
// Two instances (default and 4-bit counters) share one stimulus stream.
module tb_branch_resolve;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_predtaken;
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    logic        a_brv, a_tk, a_fl;
    logic [31:0] a_rpc;
    logic [15:0] a_bc, a_mc;
    logic        b_brv, b_tk, b_fl;
    logic [31:0] b_rpc;
    logic [3:0]  b_bc, b_mc;

    int vecs  = 0;
    int fails = 0;

    branch_resolve u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_predtaken(id_predtaken), .rs_val(rs_val), .rt_val(rt_val),
        .br_valid(a_brv), .istaken(a_tk), .flush(a_fl),
        .redirect_pc(a_rpc), .br_count(a_bc), .mp_count(a_mc)
    );

    branch_resolve #(.CNT_W(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_predtaken(id_predtaken), .rs_val(rs_val), .rt_val(rt_val),
        .br_valid(b_brv), .istaken(b_tk), .flush(b_fl),
        .redirect_pc(b_rpc), .br_count(b_bc), .mp_count(b_mc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ISA-level meaning of the instruction sitting in EX.
    function automatic void ev(input logic [31:0] ins, input logic [31:0] rs,
                               input logic [31:0] rt, output bit isb, output bit c);
        isb = 1'b1;
        c   = 1'b0;
        case (ins[31:26])
            6'h04: c = (rs == rt);
            6'h05: c = (rs != rt);
            6'h06: c = ($signed(rs) <= 0);
            6'h07: c = ($signed(rs) > 0);
            6'h01: begin
                if (ins[20:16] == 5'd0)      c = ($signed(rs) < 0);
                else if (ins[20:16] == 5'd1) c = ($signed(rs) >= 0);
                else                         isb = 1'b0;
            end
            default: isb = 1'b0;
        endcase
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    bit          m_v, m_p;
    logic [31:0] m_i, m_pc;
    int          m_br, m_mp;

    always @(posedge clk or negedge rst_n) begin
        bit isb, c, res, fl;
        if (!rst_n) begin
            m_v <= 0; m_p <= 0; m_i <= 0; m_pc <= 0;
            m_br <= 0; m_mp <= 0;
        end else if (!stall) begin
            ev(m_i, rs_val, rt_val, isb, c);
            res = m_v && isb;
            fl  = res && (c != m_p);
            m_br <= m_br + (res ? 1 : 0);
            m_mp <= m_mp + (fl ? 1 : 0);
            m_v  <= id_valid && !fl;
            m_i  <= id_instr;
            m_pc <= id_pc;
            m_p  <= id_predtaken;
        end
    end

    always @(negedge clk) begin
        bit isb, c, res, fl;
        logic [31:0] rp, tgt;
        ev(m_i, rs_val, rt_val, isb, c);
        res = m_v && isb && !stall;
        fl  = res && (c != m_p);
        tgt = m_pc + 32'd4 + (32'($signed(m_i[15:0])) << 2);
        rp  = !fl ? 32'd0 : (c ? tgt : m_pc + 32'd4);
        vecs++;
        if (a_brv !== res || a_tk !== (res && c) || a_fl !== fl || a_rpc !== rp ||
            a_bc !== 16'(sat(m_br, 65535)) || a_mc !== 16'(sat(m_mp, 65535))) begin
            fails++;
            $display("FAIL model16 t=%0t got brv=%b tk=%b fl=%b rpc=%h bc=%0d mc=%0d exp brv=%b tk=%b fl=%b rpc=%h bc=%0d mc=%0d",
                     $time, a_brv, a_tk, a_fl, a_rpc, a_bc, a_mc,
                     res, res && c, fl, rp, sat(m_br, 65535), sat(m_mp, 65535));
        end
        vecs++;
        if (b_brv !== res || b_tk !== (res && c) || b_fl !== fl || b_rpc !== rp ||
            b_bc !== 4'(sat(m_br, 15)) || b_mc !== 4'(sat(m_mp, 15))) begin
            fails++;
            $display("FAIL model4 t=%0t got brv=%b tk=%b fl=%b rpc=%h bc=%0d mc=%0d exp brv=%b tk=%b fl=%b rpc=%h bc=%0d mc=%0d",
                     $time, b_brv, b_tk, b_fl, b_rpc, b_bc, b_mc,
                     res, res && c, fl, rp, sat(m_br, 15), sat(m_mp, 15));
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] ins,
                          input logic [31:0] pc, input logic p);
        id_valid     = v;
        id_instr     = ins;
        id_pc        = pc;
        id_predtaken = p;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        set_id(0, 32'd0, 32'd0, 0);
        rs_val = 0;
        rt_val = 0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    // Issue one instruction, then resolve it with the given operands.
    task automatic run_br(input logic [31:0] ins, input logic [31:0] pc,
                          input logic p, input logic [31:0] rs, input logic [31:0] rt);
        set_id(1, ins, pc, p);
        cyc();
        set_id(0, 32'd0, 32'd0, 0);
        rs_val = rs;
        rt_val = rt;
        cyc();
    endtask

    typedef struct {
        logic [31:0] ins;
        logic        p;
        logic [31:0] rs;
        logic [31:0] rt;
    } vec_t;

    vec_t tbl[8] = '{
        '{32'h18200008, 1'b1, 32'h0,        32'h0},
        '{32'h18200008, 1'b0, 32'h00000001, 32'h0},
        '{32'h0421FFF0, 1'b0, 32'h00000005, 32'h0},
        '{32'h0421FFF0, 1'b1, 32'hFFFFFFFF, 32'h0},
        '{32'h14220010, 1'b1, 32'h3,        32'h4},
        '{32'h03E00008, 1'b1, 32'h1,        32'h2},
        '{32'h0C000100, 1'b1, 32'h0,        32'h0},
        '{32'h1C20FFFE, 1'b1, 32'h7FFFFFFF, 32'h0}
    };

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        set_id(0, 32'd0, 32'd0, 0);
        rs_val = 0;
        rt_val = 0;
        #3;
        chk("rst_brv", {31'd0, a_brv}, 32'd0);
        chk("rst_flush", {31'd0, a_fl}, 32'd0);
        chk("rst_rpc", a_rpc, 32'd0);
        chk("rst_bc", {16'd0, a_bc}, 32'd0);
        do_reset();

        // BEQ taken, predicted not-taken
        set_id(1, 32'h10220004, 32'h100, 0);
        cyc();
        set_id(0, 32'd0, 32'd0, 0);
        rs_val = 5; rt_val = 5;
        #3;
        chk("beq_brv", {31'd0, a_brv}, 32'd1);
        chk("beq_tk", {31'd0, a_tk}, 32'd1);
        chk("beq_fl", {31'd0, a_fl}, 32'd1);
        chk("beq_rpc", a_rpc, 32'h114);
        cyc();
        #3;
        chk("beq_bc", {16'd0, a_bc}, 32'd1);
        chk("beq_mc", {16'd0, a_mc}, 32'd1);
        cyc();

        // BNE not taken, predicted taken; younger ID op becomes a bubble
        set_id(1, 32'h14220003, 32'h200, 1);
        cyc();
        set_id(1, 32'h10220004, 32'h204, 0);
        rs_val = 7; rt_val = 7;
        #3;
        chk("bne_tk", {31'd0, a_tk}, 32'd0);
        chk("bne_fl", {31'd0, a_fl}, 32'd1);
        chk("bne_rpc", a_rpc, 32'h204);
        cyc();
        set_id(0, 32'd0, 32'd0, 0);
        #3;
        chk("bne_bubble", {31'd0, a_brv}, 32'd0);
        cyc();

        // BGTZ on negative rs, held by 3 stall cycles
        do_reset();
        set_id(1, 32'h1C200010, 32'h300, 0);
        cyc();
        set_id(0, 32'd0, 32'd0, 0);
        rs_val = 32'h80000000;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #3;
            chk("bgtz_stall_brv", {31'd0, a_brv}, 32'd0);
            cyc();
        end
        stall = 1'b0;
        #3;
        chk("bgtz_brv", {31'd0, a_brv}, 32'd1);
        chk("bgtz_tk", {31'd0, a_tk}, 32'd0);
        chk("bgtz_fl", {31'd0, a_fl}, 32'd0);
        cyc();
        #3;
        chk("bgtz_brv_once", {31'd0, a_brv}, 32'd0);
        chk("bgtz_bc", {16'd0, a_bc}, 32'd1);
        chk("bgtz_mc", {16'd0, a_mc}, 32'd0);
        cyc();

        // BLTZ backward by one word from pc 0
        set_id(1, 32'h0420FFFF, 32'h0, 0);
        cyc();
        set_id(0, 32'd0, 32'd0, 0);
        rs_val = 32'hFFFFFFFF;
        #3;
        chk("bltz_fl", {31'd0, a_fl}, 32'd1);
        chk("bltz_rpc", a_rpc, 32'h0);
        cyc();
        cyc();
        set_id(1, 32'h0422FFFF, 32'h40, 1);
        cyc();
        set_id(0, 32'd0, 32'd0, 0);
        #3;
        chk("regimm2_brv", {31'd0, a_brv}, 32'd0);
        chk("regimm2_fl", {31'd0, a_fl}, 32'd0);
        cyc();

        // Jump predicted taken never flushes
        set_id(1, 32'h08000040, 32'h80, 1);
        cyc();
        set_id(0, 32'd0, 32'd0, 0);
        #3;
        chk("j_fl", {31'd0, a_fl}, 32'd0);
        cyc();

        foreach (tbl[i]) run_br(tbl[i].ins, 32'h1000 + 32'(i) * 32'h10, tbl[i].p,
                                tbl[i].rs, tbl[i].rt);

        // Saturation with 17 mispredicts
        do_reset();
        for (int k = 0; k < 17; k++) run_br(32'h10220004, 32'h400, 0, 0, 0);
        #3;
        chk("sat4_bc", {28'd0, b_bc}, 32'hF);
        chk("sat4_mc", {28'd0, b_mc}, 32'hF);
        chk("cnt16_mc", {16'd0, a_mc}, 32'd17);
        cyc();

        // Reset while mispredicted BEQ is stalled in EX
        set_id(1, 32'h10220004, 32'h500, 0);
        cyc();
        set_id(0, 32'd0, 32'd0, 0);
        rs_val = 1; rt_val = 1;
        stall = 1'b1;
        #3;
        chk("rst_stall_fl", {31'd0, a_fl}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rstmid_bc", {16'd0, a_bc}, 32'd0);
        chk("rstmid_mc", {16'd0, a_mc}, 32'd0);
        cyc();
        rst_n = 1'b1;
        stall = 1'b0;
        #3;
        chk("post_rst_fl", {31'd0, a_fl}, 32'd0);
        chk("post_rst_brv", {31'd0, a_brv}, 32'd0);
        chk("post_rst_rpc", a_rpc, 32'd0);
        cyc();
        #3;
        chk("post_rst_bc", {16'd0, a_bc}, 32'd0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
